// File: rtl/lf_counter_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lf_counter_ctrl_if                                        |
// | Purpose  : Bundles the control, divider, bin2bcd and display signals |
// |            of the low-frequency counter sequencer.                   |
// | Ports    : start/signal_in/ready/done_tick/err - control             |
// |            div_*  - divider handshake (dividend, divisor, quotient)  |
// |            b2b_*  - binary-to-BCD handshake                          |
// |            bcd_out/dp - autoscaled display digits and decimal point  |
// | Modports : master = sequencer side, slave = environment side         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface lf_counter_ctrl_if #(
  parameter int PERIOD_W = 20
);
  logic                start;
  logic                signal_in;
  logic                ready;
  logic                done_tick;
  logic                err;
  logic                div_start;
  logic [29:0]         div_dvnd;
  logic [PERIOD_W-1:0] div_dvsr;
  logic [29:0]         div_quo;
  logic                div_done;
  logic                b2b_start;
  logic [19:0]         b2b_bin;
  logic [23:0]         b2b_bcd;
  logic                b2b_done;
  logic [3:0][3:0]     bcd_out;
  logic [3:0]          dp;

  modport master (
    input  start, signal_in, div_quo, div_done, b2b_bcd, b2b_done,
    output ready, done_tick, err, div_start, div_dvnd, div_dvsr,
           b2b_start, b2b_bin, bcd_out, dp
  );

  modport slave (
    output start, signal_in, div_quo, div_done, b2b_bcd, b2b_done,
    input  ready, done_tick, err, div_start, div_dvnd, div_dvsr,
           b2b_start, b2b_bin, bcd_out, dp
  );
endinterface
`default_nettype wire

// File: rtl/lf_counter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lf_counter_ctrl                                           |
// | Purpose  : Sequencer for the low-frequency counter. Measures one     |
// |            period of signal_in in microseconds, has an external      |
// |            divider form 10^9/period (milli-Hz), has an external      |
// |            bin2bcd convert it, then autoscales the six BCD digits to |
// |            four display digits plus a one-hot decimal point.         |
// | Ports    : clk, reset (async, active-high)                           |
// |            bus (lf_counter_ctrl_if.master) - control, divider,       |
// |            bin2bcd and display signals                               |
// | Options  : SIGNAL_SYNC_EN - adds a 2-flop synchronizer on signal_in  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module lf_counter_ctrl #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int PERIOD_W     = 20
) (
  input  wire logic          clk,
  input  wire logic          reset,
  lf_counter_ctrl_if.master  bus
);

  localparam int                  TICK_W     = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(CLK_FREQ_MHZ - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [29:0]         DIVIDEND   = 30'd1_000_000_000;
  localparam logic [29:0]         QUO_LIMIT  = 30'd1_000_000;

  typedef enum logic [3:0] {
    IDLE, WAIT1, COUNT, DIVS, DIVW, B2BS, B2BW, SCALE, ERR, DONE
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [PERIOD_W-1:0] period;
  logic [23:0]         digits;
  logic [1:0]          shift_cnt;
  logic                sig_src;
  logic                sig_cur;
  logic                sig_prev;
  logic                rise;
  logic                tick_wrap;
  logic [PERIOD_W-1:0] period_inc;

`ifdef SIGNAL_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], bus.signal_in};
  end
  assign sig_src = sync_q[1];
`else
  assign sig_src = bus.signal_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_cur  <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_cur  <= sig_src;
      sig_prev <= sig_cur;
    end
  end

  assign rise      = sig_cur & ~sig_prev;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  // Period value including this cycle's tick, so a rise coinciding with a
  // wrap still counts that microsecond.
  assign period_inc = (tick_wrap && (period != PERIOD_MAX)) ? period + 1'b1 : period;

  assign bus.div_dvnd = DIVIDEND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      period        <= '0;
      digits        <= '0;
      shift_cnt     <= 2'd0;
      bus.ready     <= 1'b1;
      bus.done_tick <= 1'b0;
      bus.err       <= 1'b0;
      bus.div_start <= 1'b0;
      bus.div_dvsr  <= '0;
      bus.b2b_start <= 1'b0;
      bus.b2b_bin   <= '0;
      bus.bcd_out   <= '0;
      bus.dp        <= 4'b0000;
    end else begin
      bus.div_start <= 1'b0;
      bus.b2b_start <= 1'b0;
      bus.done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.ready <= 1'b0;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (rise) begin
            tick_cnt <= '0;
            period   <= '0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
          period   <= period_inc;
          // Saturation ends the measurement at once: an input with no
          // second edge would otherwise hold the sequencer here forever.
          if (period_inc == PERIOD_MAX)
            state <= ERR;
          else if (rise)
            state <= (period_inc == '0) ? ERR : DIVS;
        end
        DIVS: begin
          bus.div_dvsr  <= period;
          bus.div_start <= 1'b1;
          state         <= DIVW;
        end
        DIVW: begin
          if (bus.div_done) begin
            if (bus.div_quo >= QUO_LIMIT) begin
              state <= ERR;
            end else begin
              bus.b2b_bin <= bus.div_quo[19:0];
              state       <= B2BS;
            end
          end
        end
        B2BS: begin
          bus.b2b_start <= 1'b1;
          state         <= B2BW;
        end
        B2BW: begin
          if (bus.b2b_done) begin
            digits    <= bus.b2b_bcd;
            shift_cnt <= 2'd0;
            state     <= SCALE;
          end
        end
        SCALE: begin
          // Drop up to two leading zeros; each shift moves the point right.
          if ((digits[23:20] == 4'd0) && (shift_cnt < 2'd2)) begin
            digits    <= {digits[19:0], 4'h0};
            shift_cnt <= shift_cnt + 2'd1;
          end else begin
            bus.bcd_out   <= digits[23:8];
            bus.dp        <= (shift_cnt == 2'd2) ? 4'b1000 :
                             (shift_cnt == 2'd1) ? 4'b0100 : 4'b0010;
            bus.err       <= 1'b0;
            bus.done_tick <= 1'b1;
            state         <= DONE;
          end
        end
        ERR: begin
          bus.bcd_out   <= '0;
          bus.dp        <= 4'b0000;
          bus.err       <= 1'b1;
          bus.done_tick <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lf_counter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_lf_counter_ctrl                                        |
// | Purpose  : Directed self-checking bench for lf_counter_ctrl. Main    |
// |            instance: 1 MHz tick, 20-bit period, with divider and     |
// |            bin2bcd models. Second instance: 4 MHz tick, 8-bit period |
// |            for the zero-period and saturation error paths.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_lf_counter_ctrl;

  localparam int DIV_LAT = 10;
  localparam int B2B_LAT = 5;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  int m_div_starts = 0;
  int m_b2b_starts = 0;
  int m_dones      = 0;
  int s_div_starts = 0;
  int s_dones      = 0;

  bit          force_en  = 1'b0;
  logic [29:0] force_quo = '0;

  lf_counter_ctrl_if #(.PERIOD_W(20)) m ();
  lf_counter_ctrl_if #(.PERIOD_W(8))  s ();

  lf_counter_ctrl #(.CLK_FREQ_MHZ(1), .PERIOD_W(20)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  lf_counter_ctrl #(.CLK_FREQ_MHZ(4), .PERIOD_W(8)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m.div_start) m_div_starts++;
    if (m.b2b_start) m_b2b_starts++;
    if (m.done_tick) m_dones++;
    if (s.div_start) s_div_starts++;
    if (s.done_tick) s_dones++;
  end

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Divider model
  initial begin
    logic [19:0] dv;
    m.div_done = 1'b0;
    m.div_quo  = '0;
    forever begin
      @(negedge clk);
      if (m.div_start) begin
        dv = m.div_dvsr;
        repeat (DIV_LAT) @(negedge clk);
        if (force_en)      m.div_quo = force_quo;
        else if (dv == 0)  m.div_quo = '1;
        else               m.div_quo = 30'(64'd1_000_000_000 / 64'(dv));
        m.div_done = 1'b1;
        @(negedge clk);
        m.div_done = 1'b0;
      end
    end
  end

  // bin2bcd model
  initial begin
    logic [19:0] bv;
    m.b2b_done = 1'b0;
    m.b2b_bcd  = '0;
    forever begin
      @(negedge clk);
      if (m.b2b_start) begin
        bv = m.b2b_bin;
        repeat (B2B_LAT) @(negedge clk);
        m.b2b_bcd  = to_bcd(int'(bv));
        m.b2b_done = 1'b1;
        @(negedge clk);
        m.b2b_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sec, input int max, input string tag);
    int k;
    k = 0;
    while (!(sec ? s.done_tick : m.done_tick) && k < max) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 64'(sec ? s.done_tick : m.done_tick), 64'(1));
  endtask

  // Start, then two rises n cycles apart; optional start pokes in COUNT/DIVW.
  task automatic run_meas(input int n, input bit poke);
    m.start = 1'b1; @(negedge clk); m.start = 1'b0;
    repeat (2) @(negedge clk);
    m.signal_in = 1'b1; @(negedge clk); m.signal_in = 1'b0;
    if (poke) begin
      repeat (n/2 - 1) @(negedge clk);
      m.start = 1'b1; @(negedge clk); m.start = 1'b0;
      repeat (n - 1 - n/2) @(negedge clk);
    end else begin
      repeat (n - 1) @(negedge clk);
    end
    m.signal_in = 1'b1; @(negedge clk); m.signal_in = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clk);
      m.start = 1'b1; @(negedge clk); m.start = 1'b0;
    end
  endtask

  initial begin
    int d0, ds0, b0;
    reset       = 1'b1;
    m.start     = 1'b0;
    m.signal_in = 1'b0;
    s.start     = 1'b0;
    s.signal_in = 1'b0;
    s.div_quo   = '0;
    s.div_done  = 1'b0;
    s.b2b_bcd   = '0;
    s.b2b_done  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",     64'(m.ready),     64'(1));
    check("rst_done",      64'(m.done_tick), 64'(0));
    check("rst_err",       64'(m.err),       64'(0));
    check("rst_div_start", 64'(m.div_start), 64'(0));
    check("rst_b2b_start", 64'(m.b2b_start), 64'(0));
    check("rst_dvsr",      64'(m.div_dvsr),  64'(0));
    check("rst_bin",       64'(m.b2b_bin),   64'(0));
    check("rst_bcd",       64'(m.bcd_out),   64'(0));
    check("rst_dp",        64'(m.dp),        64'(0));
    check("rst_s_ready",   64'(s.ready),     64'(1));
    reset = 1'b0;
    @(negedge clk);
    check("dvnd", 64'(m.div_dvnd), 64'd1_000_000_000);

    // Period 4000 us -> 250000 mHz -> "250.0", with ignored start pokes
    d0 = m_dones;
    run_meas(4000, 1'b1);
    wait_done(1'b0, 200, "p4000");
    check("p4000_dvsr", 64'(m.div_dvsr), 64'd4000);
    check("p4000_bin",  64'(m.b2b_bin),  64'd250000);
    check("p4000_bcd",  64'(m.bcd_out),  64'h2500);
    check("p4000_dp",   64'(m.dp),       64'b0010);
    check("p4000_err",  64'(m.err),      64'(0));
    repeat (40) @(negedge clk);
    check("p4000_one_done",  64'(m_dones - d0),   64'(1));
    check("p4000_one_div",   64'(m_div_starts),   64'(1));
    check("p4000_ready",     64'(m.ready),        64'(1));

    // Period 12345 us -> 81004 mHz -> "81.00"
    run_meas(12345, 1'b0);
    wait_done(1'b0, 200, "p12345");
    check("p12345_dvsr", 64'(m.div_dvsr), 64'd12345);
    check("p12345_bin",  64'(m.b2b_bin),  64'd81004);
    check("p12345_bcd",  64'(m.bcd_out),  64'h8100);
    check("p12345_dp",   64'(m.dp),       64'b0100);
    check("p12345_err",  64'(m.err),      64'(0));
    repeat (5) @(negedge clk);

    // Quotient at the limit -> error, bin2bcd never started
    b0 = m_b2b_starts;
    force_en  = 1'b1;
    force_quo = 30'd1_000_000;
    run_meas(50, 1'b0);
    wait_done(1'b0, 200, "qlim");
    check("qlim_err", 64'(m.err),     64'(1));
    check("qlim_bcd", 64'(m.bcd_out), 64'(0));
    check("qlim_dp",  64'(m.dp),      64'(0));
    repeat (5) @(negedge clk);
    check("qlim_no_b2b", 64'(m_b2b_starts - b0), 64'(0));
    check("qlim_err_held", 64'(m.err), 64'(1));

    // Quotient 2000 mHz -> two shifts -> "2.000"; err cleared
    force_quo = 30'd2000;
    run_meas(50, 1'b0);
    wait_done(1'b0, 200, "q2000");
    check("q2000_bcd", 64'(m.bcd_out), 64'h2000);
    check("q2000_dp",  64'(m.dp),      64'b1000);
    check("q2000_err", 64'(m.err),     64'(0));
    force_en = 1'b0;
    repeat (5) @(negedge clk);

    // Reset while waiting on the divider
    d0 = m_dones;
    run_meas(20, 1'b0);
    repeat (3) @(negedge clk);
    check("rdivw_busy", 64'(m.ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rdivw_ready", 64'(m.ready),   64'(1));
    check("rdivw_bcd",   64'(m.bcd_out), 64'(0));
    check("rdivw_dp",    64'(m.dp),      64'(0));
    check("rdivw_dvsr",  64'(m.div_dvsr),64'(0));
    check("rdivw_err",   64'(m.err),     64'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rdivw_no_done",  64'(m_dones - d0), 64'(0));
    check("rdivw_idle",     64'(m.ready),      64'(1));
    check("rdivw_bin_zero", 64'(m.b2b_bin),    64'(0));

    // Second instance: zero period (two rises inside one tick)
    s.start = 1'b1; @(negedge clk); s.start = 1'b0;
    repeat (2) @(negedge clk);
    s.signal_in = 1'b1; @(negedge clk); s.signal_in = 1'b0;
    @(negedge clk);
    s.signal_in = 1'b1; @(negedge clk); s.signal_in = 1'b0;
    wait_done(1'b1, 50, "zero");
    check("zero_err", 64'(s.err),     64'(1));
    check("zero_bcd", 64'(s.bcd_out), 64'(0));
    check("zero_dp",  64'(s.dp),      64'(0));
    repeat (5) @(negedge clk);

    // Second instance: period saturates at 255 us (1020 cycles)
    ds0 = s_dones;
    s.start = 1'b1; @(negedge clk); s.start = 1'b0;
    repeat (2) @(negedge clk);
    s.signal_in = 1'b1; @(negedge clk); s.signal_in = 1'b0;
    wait_done(1'b1, 1300, "sat");
    check("sat_err", 64'(s.err),     64'(1));
    check("sat_bcd", 64'(s.bcd_out), 64'(0));
    check("sat_dp",  64'(s.dp),      64'(0));
    repeat (5) @(negedge clk);
    check("sat_one_done", 64'(s_dones - ds0), 64'(1));
    check("s_no_div",     64'(s_div_starts),  64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lf_counter_ctrl.md
Name: lf_counter_ctrl

Overview:
- Sequencer for the low-frequency counter FSMD.
- On a start pulse it measures one period of signal_in in microseconds, then drives an external divider to form frequency = 10^9 / period_us (milli-Hz).
- It then drives an external binary-to-BCD converter and autoscales the 6-digit result to 4 display digits plus a one-hot decimal point.
- It feeds the display wrapper's bcd/autoscale registers.

Parameters:
- CLK_FREQ_MHZ, 100, clk frequency in MHz; sets the 1 us tick divisor.
- PERIOD_W, 20, period counter width in us; saturation = 2^PERIOD_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; honoured only when ready=1.
- signal_in  in  1  measured input.
- ready  out  1  high in IDLE.
- done_tick  out  1  one-cycle pulse when results are updated.
- err  out  1  error flag; valid with done_tick, held until next done_tick.
- div_start  out  1  one-cycle pulse to the divider.
- div_dvnd  out  30  dividend, constant 1_000_000_000.
- div_dvsr  out  PERIOD_W  divisor = measured period; held stable from div_start until div_done.
- div_quo  in  30  quotient; sampled when div_done=1.
- div_done  in  1  divider completion pulse.
- b2b_start  out  1  one-cycle pulse to bin2bcd.
- b2b_bin  out  20  binary value to convert; held stable until b2b_done.
- b2b_bcd  in  24  six BCD digits, d5 in [23:20] down to d0 in [3:0].
- b2b_done  in  1  bin2bcd completion pulse.
- bcd_out  out  4x4  display digits, bcd_out[3] is the MSD.
- dp  out  4  one-hot decimal point; bit i = point to the right of bcd_out[i].

Behaviour:
- Reset: state IDLE, ready=1, done_tick=0, err=0, div_start=0, b2b_start=0, div_dvsr=0, b2b_bin=0, bcd_out all 0, dp=0, all counters 0.
- Reset mid-operation aborts immediately to IDLE; the divider and bin2bcd are not notified.
- Rising edge detect: signal_in registered once; rise = cur & ~prev.
- FSM states and transitions:
  - IDLE: start -> WAIT1. Outputs hold their last values. start in any other state is ignored.
  - WAIT1: on the first rise, clear the tick counter and period counter -> COUNT.
  - COUNT: tick counter counts 0..CLK_FREQ_MHZ-1. At wrap, period increments and saturates at 2^PERIOD_W-1. On the next rise -> DIVS.
    - If a rise and a tick wrap occur in the same cycle, the increment is included.
    - If period==0 on the rise, or period is saturated -> ERR.
  - DIVS: div_dvsr<=period, pulse div_start for 1 cycle -> DIVW.
  - DIVW: wait for div_done; no timeout.
    - If div_quo>=1_000_000 -> ERR.
    - Else b2b_bin<=div_quo[19:0] -> B2BS.
  - B2BS: pulse b2b_start for 1 cycle -> B2BW.
  - B2BW: wait for b2b_done; latch b2b_bcd into the digit shift register, set shift count=0 -> SCALE.
  - SCALE: one digit per cycle.
    - If d5==0 and shift count<2, shift the register left one digit (zero-fill) and increment the count.
    - Otherwise load bcd_out = top four digits and set dp: 2 shifts=4'b1000, 1 shift=4'b0100, 0 shifts=4'b0010. Then -> DONE.
  - ERR: bcd_out=0, dp=0, err=1 -> DONE.
  - DONE: done_tick=1 for 1 cycle; err=0 unless entered from ERR -> IDLE.
- Displayed value equals frequency in Hz, e.g. "2.000", "81.00", "250.0".
- Latency: input-edge dependent; from the second rise to done_tick = 2 + divider latency + bin2bcd latency + 1..3 SCALE cycles + 1.

Optional Feature:
- SIGNAL_SYNC_EN.
- Defined: signal_in passes through a 2-flop synchronizer before the edge detect; edges are seen 2 cycles later.
- Undefined: signal_in is treated as synchronous to clk and goes straight to the edge register.

Test Plan:
- CLK_FREQ_MHZ=1, signal_in period 500_000 us, start -> div_dvsr=500000; quotient 2000 -> bcd_out={2,0,0,0}, dp=1000, err=0, one done_tick.
- Period 4_000 us -> quotient 250000 -> bcd_out={2,5,0,0}, dp=0010.
- Period 12_345 us -> quotient 81004 -> bcd_out={8,1,0,0}, dp=0100.
- signal_in held low after the first rise past 2^20-1 us -> err=1, bcd_out=0, dp=0, no div_start ever issued. Separately, period 0 (two rises within one tick) -> err=1.
- start pulsed during COUNT and DIVW -> ignored, single done_tick. Reset asserted in DIVW -> ready=1 next cycle, all outputs 0, later div_done ignored.
- Divider model returning quotient 1_000_000 -> err=1, b2b_start never pulses.
